s2mm_burst_writer: RTL and testbench
====================================

Name: s2mm_burst_writer

Overview:
Parametrised stream-to-memory write engine. It accepts a byte-length write command (address, length, req/ack), pulls a valid/ready data stream, and emits AXI4 INCR write bursts on an HP port. Bursts are split at MAX_BURST beats and at 4 KB boundaries, and the last beat carries a partial strobe. Successor to the fixed 64-bit write path of datamover_ctrl.

Parameters:
DATA_WIDTH, 64, AXI/stream data width in bits (power of 2, 32..1024); BYTES = DATA_WIDTH/8
ADDR_WIDTH, 32, AXI address width
LEN_WIDTH, 23, command length width in bytes
MAX_BURST, 16, maximum beats per burst (1..256)
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant value driven on m_axi_awid

Ports:
clk  in  1  clock
rst  in  1  reset
i_wr_cmd_addr  in  ADDR_WIDTH  start byte address; low log2(BYTES) bits ignored (treated as 0)
i_wr_cmd_length  in  LEN_WIDTH  transfer length in bytes
i_wr_cmd_req  in  1  command request, level
o_wr_cmd_ack  out  1  one-cycle command accept pulse
i_wr_valid  in  1  stream data valid
i_wr_data  in  DATA_WIDTH  stream data
o_wr_ready  out  1  stream data ready
o_write_finish  out  1  one-cycle pulse, command complete
o_write_error  out  1  valid with finish; 1 if any bresp != OKAY during the command
m_axi_awvalid/awready  out/in  1  AW handshake
m_axi_awid  out  ID_WIDTH  = AXI_ID
m_axi_awaddr  out  ADDR_WIDTH  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  log2(BYTES)
m_axi_awburst  out  2  2'b01 (INCR)
m_axi_awcache  out  4  4'b0011
m_axi_awprot  out  3  3'b000
m_axi_wdata  out  DATA_WIDTH  = i_wr_data
m_axi_wstrb  out  BYTES  byte strobes
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid/wready  out/in  1  W handshake
m_axi_bresp  in  2  write response
m_axi_bvalid/bready  in/out  1  B handshake

Behaviour:
- Single clock clk; rst asynchronous, active-high. On reset: FSM IDLE; o_wr_cmd_ack, o_wr_ready, o_write_finish, o_write_error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready all 0; awaddr/awlen 0.
- FSM: IDLE -> CALC -> AW -> W -> B -> (CALC | DONE) -> IDLE.
- IDLE: i_wr_cmd_req sampled 1 at edge N -> addr/length latched; ack high for cycle N+1 only; state CALC. Req while not in IDLE is ignored; no ack.
- Length 0: ack, then DONE (finish pulse, error 0) with no AXI traffic.
- Total beats = ceil(len/BYTES), held in a counter of LEN_WIDTH-log2(BYTES)+1 bits.
- CALC (1 cycle): burst = min(remaining, MAX_BURST, (4096 - addr[11:0])/BYTES); awlen = burst-1.
- AW: awvalid held with stable addr/len until awready; then W. awvalid is asserted 2 cycles after the req edge.
- W: pass-through with zero latency. m_axi_wvalid = i_wr_valid & inW; o_wr_ready = m_axi_wready & inW. Beat counted on wvalid&wready.
  - wlast is 1 on the burst's final beat.
  - wstrb is all ones, except on the command's final beat when len mod BYTES = k != 0, where wstrb = (1<<k)-1.
  - After the wlast handshake, go to B.
- B: bready = 1. On bvalid, OR (bresp != 0) into the sticky error flag; addr += burst*BYTES; remaining -= burst. Next state is CALC if remaining != 0, else DONE.
- DONE (1 cycle): o_write_finish = 1, o_write_error = sticky flag; flag cleared; then IDLE.
- Only one burst is outstanding at a time. o_wr_ready is 0 outside W, so data is never accepted early.
- Reset mid-operation abandons the command immediately and drops all valids; the bench resets the slave together with this block.

Optional Feature:
S2MM_STATS_EN:
- Defined: adds outputs o_stat_bursts[31:0] (incremented per completed B handshake) and o_stat_errors[31:0] (incremented per non-OKAY bresp). Both are free-running, wrap at 2^32, and reset to 0.
- Undefined: neither port nor counter logic exists.

Test Plan:
- addr 0x8, len 16, DATA_WIDTH 64 -> one burst: awaddr 0x8, awlen 1, wstrb 0xFF/0xFF, wlast on beat 2, one finish pulse, error 0.
- addr 0x0, len 13 -> awlen 1, beat-2 wstrb 0x1F, finish; lengths 1..32 swept back-to-back, each followed by exactly ceil(len/8) accepted beats.
- addr 0x0, len 200, MAX_BURST 16 -> bursts awaddr 0x000 awlen 15 and awaddr 0x080 awlen 8, last wstrb 0xFF, one finish.
- addr 0xFF8, len 24 -> awaddr 0xFF8 awlen 0, then awaddr 0x1000 awlen 1; no burst crosses 4 KB.
- len 200 with slave returning SLVERR on the 2nd burst -> both bursts complete, finish with error 1; the next command finishes with error 0.
- len 0 -> ack, finish pulse, no awvalid. Separately, rst asserted during W -> next cycle all outputs at reset values, and a new command completes normally.

Source files
------------

// File: rtl/s2mm_burst_writer.sv
// s2mm_burst_writer
// Stream-to-memory write engine. A byte-length command (address, length,
// req/ack) is turned into a sequence of AXI4 INCR write bursts. Each burst is
// capped at MAX_BURST beats and never crosses a 4 KB boundary. The stream is
// passed straight through to the W channel. The last beat of a command carries
// a partial strobe when the length is not a multiple of the bus width.
//
// Optional feature macro: S2MM_STATS_EN. When it is defined, two free-running
// counters are added on o_stat_bursts and o_stat_errors.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_wr_cmd_addr/length/req  command input (req is a level)
//   o_wr_cmd_ack              one-cycle pulse when a command is accepted
//   i_wr_valid/data, o_wr_ready  input data stream
//   o_write_finish/error      one-cycle completion pulse and its error flag
//   m_axi_aw*, m_axi_w*, m_axi_b*  AXI4 write channels (HP port)
//   o_stat_bursts/errors      (S2MM_STATS_EN only) burst and error counters
module s2mm_burst_writer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 23,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   i_wr_cmd_addr,
    input  logic [LEN_WIDTH-1:0]    i_wr_cmd_length,
    input  logic                    i_wr_cmd_req,
    output logic                    o_wr_cmd_ack,
    input  logic                    i_wr_valid,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_wr_ready,
    output logic                    o_write_finish,
    output logic                    o_write_error,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
`ifdef S2MM_STATS_EN
    ,
    output logic [31:0]             o_stat_bursts,
    output logic [31:0]             o_stat_errors
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int BW    = LEN_WIDTH - SZ + 1;       // beat counter width
    localparam int CW    = (BW > 13) ? BW : 13;      // width used for the burst min()

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BW-1:0]         r_remaining;
    logic [SZ-1:0]         r_tail;        // length mod BYTES
    logic [8:0]            r_burst;
    logic [7:0]            r_beat;
    logic                  r_err;
    logic                  r_ack;
    logic                  r_finish;
    logic                  r_error_out;
    logic                  r_awvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_awlen;
    logic                  r_bready;

    // Beats in the command: ceil(len / BYTES), one extra bit so the rounding
    // add cannot overflow.
    logic [LEN_WIDTH:0]    w_len_ext;
    logic [BW-1:0]         w_cmd_beats;
    assign w_len_ext   = {1'b0, i_wr_cmd_length} + (LEN_WIDTH+1)'(BYTES - 1);
    assign w_cmd_beats = BW'(w_len_ext >> SZ);

    // Beats left before the next 4 KB boundary.
    logic [12:0]           w_to_4k;
    logic [CW-1:0]         w_lim_4k;
    logic [CW-1:0]         w_min;
    logic [8:0]            w_burst;
    assign w_to_4k  = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_lim_4k = CW'(w_to_4k >> SZ);

    always_comb begin
        w_min = CW'(r_remaining);
        if (CW'(MAX_BURST) < w_min) w_min = CW'(MAX_BURST);
        if (w_lim_4k < w_min)       w_min = w_lim_4k;
    end
    assign w_burst = 9'(w_min);

    logic                  w_in_w;
    logic                  w_last_beat;
    logic                  w_final_beat;
    logic [BYTES-1:0]      w_tail_mask;
    logic                  w_w_hs;

    assign w_in_w       = (r_state == S_W);
    assign w_last_beat  = (r_beat == r_awlen);
    // Last beat of the burst that empties the command.
    assign w_final_beat = w_last_beat && (r_remaining == BW'(r_burst));
    assign w_w_hs       = m_axi_wvalid && m_axi_wready;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_tail
            assign w_tail_mask[gi] = (gi < int'(r_tail));
        end
    endgenerate

    // W channel is a combinational pass-through gated by the W state.
    assign m_axi_wvalid  = i_wr_valid && w_in_w;
    assign o_wr_ready    = m_axi_wready && w_in_w;
    assign m_axi_wdata   = i_wr_data;
    assign m_axi_wlast   = w_in_w && w_last_beat;
    assign m_axi_wstrb   = (w_final_beat && (r_tail != '0)) ? w_tail_mask : '1;

    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awsize  = 3'(SZ);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_bready  = r_bready;
    assign o_wr_cmd_ack  = r_ack;
    assign o_write_finish = r_finish;
    assign o_write_error = r_error_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_tail      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_err       <= 1'b0;
            r_ack       <= 1'b0;
            r_finish    <= 1'b0;
            r_error_out <= 1'b0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_bready    <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_finish    <= 1'b0;
            r_error_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_wr_cmd_req) begin
                        r_addr      <= i_wr_cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
                        r_remaining <= w_cmd_beats;
                        r_tail      <= i_wr_cmd_length[SZ-1:0];
                        r_ack       <= 1'b1;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_remaining == '0) begin
                        // Zero-length command, or nothing left.
                        r_finish    <= 1'b1;
                        r_error_out <= r_err;
                        r_err       <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_burst   <= w_burst;
                        r_awaddr  <= r_addr;
                        r_awlen   <= 8'(w_burst - 9'd1);
                        r_awvalid <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_AW;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + 8'd1;
                        if (w_last_beat) begin
                            r_bready <= 1'b1;
                            r_state  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_addr      <= r_addr + (ADDR_WIDTH'(r_burst) << SZ);
                        r_remaining <= r_remaining - BW'(r_burst);
                        if (r_remaining == BW'(r_burst)) begin
                            r_finish    <= 1'b1;
                            r_error_out <= r_err || (m_axi_bresp != 2'b00);
                            r_err       <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            if (m_axi_bresp != 2'b00) r_err <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef S2MM_STATS_EN
    logic [31:0] r_stat_bursts;
    logic [31:0] r_stat_errors;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_bursts <= '0;
            r_stat_errors <= '0;
        end else if ((r_state == S_B) && m_axi_bvalid) begin
            r_stat_bursts <= r_stat_bursts + 32'd1;
            if (m_axi_bresp != 2'b00) r_stat_errors <= r_stat_errors + 32'd1;
        end
    end

    assign o_stat_bursts = r_stat_bursts;
    assign o_stat_errors = r_stat_errors;
`endif

endmodule

// File: tb/tb_s2mm_burst_writer.sv
// Testbench for s2mm_burst_writer (default parameters, 64-bit bus).
// A reference model computes the expected AW bursts and W beats of each
// command from address/length arithmetic. A negedge monitor checks every
// handshake against the model. A randomised slave and stream source drive the
// DUT, and the slave can inject SLVERR on a chosen burst.
module tb_s2mm_burst_writer;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int LW = 23;
    localparam int MB = 16;
    localparam int BY = DW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  i_wr_cmd_addr;
    logic [LW-1:0]  i_wr_cmd_length;
    logic           i_wr_cmd_req;
    logic           o_wr_cmd_ack;
    logic           i_wr_valid;
    logic [DW-1:0]  i_wr_data;
    logic           o_wr_ready;
    logic           o_write_finish;
    logic           o_write_error;
    logic           m_axi_awvalid;
    logic           m_axi_awready;
    logic [3:0]     m_axi_awid;
    logic [AW-1:0]  m_axi_awaddr;
    logic [7:0]     m_axi_awlen;
    logic [2:0]     m_axi_awsize;
    logic [1:0]     m_axi_awburst;
    logic [3:0]     m_axi_awcache;
    logic [2:0]     m_axi_awprot;
    logic [DW-1:0]  m_axi_wdata;
    logic [BY-1:0]  m_axi_wstrb;
    logic           m_axi_wlast;
    logic           m_axi_wvalid;
    logic           m_axi_wready;
    logic [1:0]     m_axi_bresp;
    logic           m_axi_bvalid;
    logic           m_axi_bready;

    always #5 clk = ~clk;

    s2mm_burst_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .MAX_BURST(MB), .ID_WIDTH(4), .AXI_ID(0)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wr_cmd_addr(i_wr_cmd_addr), .i_wr_cmd_length(i_wr_cmd_length),
        .i_wr_cmd_req(i_wr_cmd_req), .o_wr_cmd_ack(o_wr_cmd_ack),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_write_finish(o_write_finish), .o_write_error(o_write_error),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  l;
    } aw_t;

    aw_t        exp_aw[$];
    logic [7:0] exp_strb[$];
    bit         exp_last[$];
    aw_t        act_aw[$];
    logic [7:0] act_strb[$];

    // Model: walk the command from the aligned start address, cutting bursts
    // at MB beats and at the next 4 KB boundary.
    function automatic int model_cmd(input logic [31:0] addr, input int len);
        logic [31:0] a;
        int beats, done, b, room, nb, k;
        aw_t e;
        a = addr & ~32'(BY - 1);
        beats = (len + BY - 1) / BY;
        k = len % BY;
        done = 0;
        nb = 0;
        while (done < beats) begin
            room = (4096 - int'(a % 4096)) / BY;
            b = beats - done;
            if (b > MB) b = MB;
            if (b > room) b = room;
            e.a = a;
            e.l = 8'(b - 1);
            exp_aw.push_back(e);
            for (int j = 0; j < b; j++) begin
                if ((done + j == beats - 1) && k != 0) exp_strb.push_back(8'hFF >> (BY - k));
                else exp_strb.push_back(8'hFF);
                exp_last.push_back(j == b - 1);
            end
            a = a + 32'(b * BY);
            done += b;
            nb++;
        end
        return nb;
    endfunction

    // Slave / source knobs and shared bookkeeping.
    int rdy_pct = 70;
    int val_pct = 70;
    int err_at  = -1;
    int b_done  = 0;
    int b_owed  = 0;
    bit b_hs    = 0;
    bit s_hs    = 0;
    int beats_acc = 0;
    int ack_cnt   = 0;
    int awv_cycles = 0;
    bit mon_en    = 1;

    // Slave and stream driver: changes inputs 1 time unit after the edge.
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        i_wr_valid = 0; i_wr_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                i_wr_valid = 0; b_owed = 0; b_hs = 0; s_hs = 0;
            end else begin
                m_axi_awready = ($urandom % 100) < rdy_pct;
                m_axi_wready  = ($urandom % 100) < rdy_pct;
                if (m_axi_bvalid && b_hs) begin
                    m_axi_bvalid = 0;
                    b_done++;
                end
                b_hs = 0;
                if (!m_axi_bvalid && b_owed > 0 && ($urandom % 3) == 0) begin
                    m_axi_bvalid = 1;
                    m_axi_bresp  = (b_done == err_at) ? 2'b10 : 2'b00;
                    b_owed--;
                end
                if (s_hs || !i_wr_valid) begin
                    i_wr_valid = ($urandom % 100) < val_pct;
                    i_wr_data  = {$urandom, $urandom};
                end
                s_hs = 0;
            end
        end
    end

    // Monitor: compares every handshake against the model.
    initial begin
        bit          stall;
        logic [31:0] p_addr;
        logic [7:0]  p_len;
        aw_t         e;
        aw_t         got;
        stall = 0;
        p_addr = '0;
        p_len = '0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("aw_held", m_axi_awvalid, 1'b1);
                    chk("aw_addr_stable", m_axi_awaddr, p_addr);
                    chk("aw_len_stable", m_axi_awlen, p_len);
                end
                stall  = m_axi_awvalid && !m_axi_awready;
                p_addr = m_axi_awaddr;
                p_len  = m_axi_awlen;
                if (m_axi_awvalid) awv_cycles++;
                if (o_wr_cmd_ack) ack_cnt++;
                if (m_axi_wvalid) chk("wvalid_src", i_wr_valid, 1'b1);
                if (o_wr_ready) chk("ready_src", m_axi_wready, 1'b1);
                if ((m_axi_wvalid && m_axi_wready) || (i_wr_valid && o_wr_ready))
                    chk("hs_equiv", m_axi_wvalid && m_axi_wready, i_wr_valid && o_wr_ready);
                if (m_axi_awvalid && m_axi_awready) begin
                    got.a = m_axi_awaddr;
                    got.l = m_axi_awlen;
                    act_aw.push_back(got);
                    if (exp_aw.size() == 0) begin
                        chk("aw_unexpected", 1, 0);
                    end else begin
                        e = exp_aw.pop_front();
                        chk("awaddr", m_axi_awaddr, e.a);
                        chk("awlen", m_axi_awlen, e.l);
                    end
                    chk("awsize", m_axi_awsize, 3);
                    chk("awburst", m_axi_awburst, 1);
                    chk("awcache", m_axi_awcache, 3);
                    chk("awprot", m_axi_awprot, 0);
                    chk("awid", m_axi_awid, 0);
                    chk("aw_4k", (int'(m_axi_awaddr % 4096) + (int'(m_axi_awlen) + 1) * BY) <= 4096, 1);
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    beats_acc++;
                    s_hs = 1;
                    act_strb.push_back(m_axi_wstrb);
                    chk("wdata", m_axi_wdata, i_wr_data);
                    if (exp_strb.size() == 0) begin
                        chk("w_unexpected", 1, 0);
                    end else begin
                        chk("wstrb", m_axi_wstrb, exp_strb.pop_front());
                        chk("wlast", m_axi_wlast, exp_last.pop_front());
                    end
                    if (m_axi_wlast) b_owed++;
                end
                if (m_axi_bvalid && m_axi_bready) b_hs = 1;
            end
        end
    end

    task automatic start_cmd(input logic [31:0] addr, input int len);
        act_aw.delete();
        act_strb.delete();
        beats_acc = 0;
        ack_cnt = 0;
        awv_cycles = 0;
        @(posedge clk);
        #1;
        i_wr_cmd_addr = addr;
        i_wr_cmd_length = LW'(len);
        i_wr_cmd_req = 1;
        @(posedge clk);
        #1;
        i_wr_cmd_req = 0;
        @(negedge clk);
        chk("ack_pulse", o_wr_cmd_ack, 1'b1);
    endtask

    // err_rel: index within this command of the burst answered with SLVERR
    // (-1 for none).
    task automatic do_cmd(input logic [31:0] addr, input int len, input int err_rel);
        int nb;
        bit got;
        bit exp_err;
        nb = model_cmd(addr, len);
        err_at = (err_rel >= 0) ? b_done + err_rel : -1;
        exp_err = (err_rel >= 0) && (err_rel < nb);
        start_cmd(addr, len);
        got = 0;
        for (int t = 0; t < 6000 && !got; t++) begin
            @(negedge clk);
            if (t == 0) begin
                chk("ack_one_cycle", o_wr_cmd_ack, 1'b0);
                chk("awvalid_at_2", m_axi_awvalid, len != 0);
            end
            if (o_write_finish) got = 1;
        end
        chk("finish_seen", got, 1);
        if (got) begin
            chk("finish_error", o_write_error, exp_err);
            @(negedge clk);
            chk("finish_one_cycle", o_write_finish, 1'b0);
        end
        chk("beats_accepted", beats_acc, (len + BY - 1) / BY);
        chk("aw_left", exp_aw.size(), 0);
        chk("w_left", exp_strb.size(), 0);
        chk("ack_count", ack_cnt, 1);
        if (len == 0) chk("no_awvalid_len0", awv_cycles, 0);
        err_at = -1;
        $display("cmd addr=0x%08h len=%0d bursts=%0d err_exp=%0d", addr, len, nb, exp_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awvalid"}, m_axi_awvalid, 0);
        chk({tag, "_wvalid"}, m_axi_wvalid, 0);
        chk({tag, "_wlast"}, m_axi_wlast, 0);
        chk({tag, "_bready"}, m_axi_bready, 0);
        chk({tag, "_ack"}, o_wr_cmd_ack, 0);
        chk({tag, "_ready"}, o_wr_ready, 0);
        chk({tag, "_finish"}, o_write_finish, 0);
        chk({tag, "_error"}, o_write_error, 0);
        chk({tag, "_awaddr"}, m_axi_awaddr, 0);
        chk({tag, "_awlen"}, m_axi_awlen, 0);
    endtask

    initial begin
        bit reached;
        int nb;
        rst = 1;
        i_wr_cmd_req = 0;
        i_wr_cmd_addr = '0;
        i_wr_cmd_length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 0;

        // Single burst, aligned to 8.
        do_cmd(32'h8, 16, -1);
        chk("d1_nbursts", act_aw.size(), 1);
        if (act_aw.size() == 1) begin
            chk("d1_awaddr", act_aw[0].a, 32'h8);
            chk("d1_awlen", act_aw[0].l, 1);
        end
        if (act_strb.size() == 2) begin
            chk("d1_strb0", act_strb[0], 8'hFF);
            chk("d1_strb1", act_strb[1], 8'hFF);
        end

        // Partial last strobe.
        do_cmd(32'h0, 13, -1);
        if (act_strb.size() == 2) chk("d2_strb1", act_strb[1], 8'h1F);
        else chk("d2_nbeats", act_strb.size(), 2);

        // Split at MAX_BURST.
        do_cmd(32'h0, 200, -1);
        chk("d3_nbursts", act_aw.size(), 2);
        if (act_aw.size() == 2) begin
            chk("d3_aw0", act_aw[0], {32'h0, 8'd15});
            chk("d3_aw1", act_aw[1], {32'h80, 8'd8});
        end
        if (act_strb.size() == 25) chk("d3_last_strb", act_strb[24], 8'hFF);

        // Split at the 4 KB boundary.
        do_cmd(32'hFF8, 24, -1);
        chk("d4_nbursts", act_aw.size(), 2);
        if (act_aw.size() == 2) begin
            chk("d4_aw0", act_aw[0], {32'hFF8, 8'd0});
            chk("d4_aw1", act_aw[1], {32'h1000, 8'd1});
        end

        // SLVERR on the second burst; the next command must be clean.
        do_cmd(32'h0, 200, 1);
        do_cmd(32'h0, 64, -1);

        // Zero length.
        do_cmd(32'h100, 0, -1);

        // Length sweep, back to back.
        for (int len = 1; len <= 32; len++) begin
            do_cmd($urandom & 32'h1FF8, len, -1);
        end

        // Random commands with random ready pressure and error injection.
        for (int i = 0; i < 25; i++) begin
            rdy_pct = 30 + int'($urandom % 71);
            val_pct = 30 + int'($urandom % 71);
            do_cmd($urandom, int'($urandom_range(1, 700)),
                   (($urandom % 4) == 0) ? int'($urandom % 4) : -1);
        end
        rdy_pct = 70;
        val_pct = 70;

        // Reset during the W phase.
        nb = model_cmd(32'h40, 200);
        start_cmd(32'h40, 200);
        reached = 0;
        for (int t = 0; t < 3000 && !reached; t++) begin
            @(negedge clk);
            if (beats_acc >= 3) reached = 1;
        end
        chk("reached_w_phase", reached, 1);
        @(posedge clk);
        #2;
        rst = 1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_aw.delete();
        exp_strb.delete();
        exp_last.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        $display("reset mid-command (bursts planned=%0d)", nb);
        do_cmd(32'h200, 40, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
